// File: rtl/ps2_pkg.sv
// Shared scan-code constants and receiver state encoding for the PS/2 keyboard front end.
package ps2_pkg;

  localparam logic [7:0] SC_E0   = 8'hE0;
  localparam logic [7:0] SC_F0   = 8'hF0;
  localparam logic [7:0] SC_CTRL = 8'h14;
  localparam logic [7:0] SC_ALT  = 8'h11;
  localparam logic [7:0] SC_DEL  = 8'h71;
  localparam logic [7:0] SC_BKSP = 8'h66;
  localparam logic [7:0] SC_F6   = 8'h0B;
  localparam logic [7:0] SC_F7   = 8'h83;
  localparam logic [7:0] SC_F8   = 8'h0A;
  localparam logic [7:0] SC_F11  = 8'h78;
  localparam logic [7:0] SC_F12  = 8'h07;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronises and filters the pins, then deserialises
// 11-bit frames, flagging good bytes and dropped frames (bad framing, parity or timeout).
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 4095
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] ps2,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       rx_error
);

  localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  logic            clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
  logic            dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
  logic            filt_q, filt_d;
  logic [FW-1:0]   filt_cnt_q, filt_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  rx_state_t       state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            fall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      to_cnt_q   <= '0;
      state_q    <= RX_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
    end else begin
      clk_meta_q <= clk_meta_d;
      clk_sync_q <= clk_sync_d;
      dat_meta_q <= dat_meta_d;
      dat_sync_q <= dat_sync_d;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      to_cnt_q   <= to_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
    end
  end

  always_comb begin
    clk_meta_d = clk_meta_q;
    clk_sync_d = clk_sync_q;
    dat_meta_d = dat_meta_q;
    dat_sync_d = dat_sync_q;
    filt_d     = filt_q;
    filt_cnt_d = filt_cnt_q;
    to_cnt_d   = to_cnt_q;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    byte_valid = 1'b0;
    rx_error   = 1'b0;
    fall       = 1'b0;

    if (ce) begin
      clk_meta_d = ps2[0];
      clk_sync_d = clk_meta_q;
      dat_meta_d = ps2[1];
      dat_sync_d = dat_meta_q;

      // The filtered clock only flips after FILTER consecutive disagreeing samples.
      filt_cnt_d = '0;
      if (clk_sync_q != filt_q) begin
        if (filt_cnt_q == FILT_LAST) begin
          filt_d = clk_sync_q;
        end else begin
          filt_cnt_d = filt_cnt_q + 1'b1;
        end
      end
      fall = filt_q & ~filt_d;

      if (state_q == RX_IDLE || fall) begin
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end

      unique case (state_q)
        RX_IDLE: begin
          if (fall) begin
            if (!dat_sync_q) begin
              state_d   = RX_DATA;
              bit_cnt_d = '0;
            end else begin
              rx_error = 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (fall) begin
            shift_d   = {dat_sync_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = RX_PARITY;
            end
          end
        end
        RX_PARITY: begin
          if (fall) begin
            par_d   = dat_sync_q;
            state_d = RX_STOP;
          end
        end
        RX_STOP: begin
          if (fall) begin
            state_d = RX_IDLE;
            if (dat_sync_q && (^{shift_q, par_q})) begin
              byte_valid = 1'b1;
            end else begin
              rx_error = 1'b1;
            end
          end
        end
        default: state_d = RX_IDLE;
      endcase

      // A stalled partial frame is abandoned and reported like a bad frame.
      if (state_q != RX_IDLE && !fall && to_cnt_q == TO_LAST) begin
        state_d  = RX_IDLE;
        to_cnt_d = '0;
        rx_error = 1'b1;
      end
    end
  end

  assign rx_byte = shift_q;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end: turns received bytes into make/break key events and
// tracks the held state of the hot keys used by the system control logic.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 4095
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] ps2,
  output logic       keyStrb,
  output logic       keyPrss,
  output logic [7:0] keyCode,
  output logic       keyExt,
  output logic       reset_n,
  output logic       boot_n,
  output logic       f12,
  output logic       f11,
  output logic       f8,
  output logic       f7,
  output logic       f6
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       rx_error;

  ps2_rx #(
    .FILTER (FILTER),
    .TIMEOUT(TIMEOUT)
  ) u_rx (
    .clock     (clock),
    .reset     (reset),
    .ce        (ce),
    .ps2       (ps2),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .rx_error  (rx_error)
  );

  logic       ext_q, ext_d, brk_q, brk_d;
  logic       key_strb_q, key_strb_d, key_prss_q, key_prss_d, key_ext_q, key_ext_d;
  logic [7:0] key_code_q, key_code_d;
  logic       ctrl_q, ctrl_d, alt_q, alt_d, del_q, del_d, bksp_q, bksp_d;
  logic       f6_q, f6_d, f7_q, f7_d, f8_q, f8_d, f11_q, f11_d, f12_q, f12_d;
  logic       press;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      key_strb_q <= 1'b0;
      key_prss_q <= 1'b0;
      key_ext_q  <= 1'b0;
      key_code_q <= 8'h00;
      ctrl_q     <= 1'b0;
      alt_q      <= 1'b0;
      del_q      <= 1'b0;
      bksp_q     <= 1'b0;
      f6_q       <= 1'b0;
      f7_q       <= 1'b0;
      f8_q       <= 1'b0;
      f11_q      <= 1'b0;
      f12_q      <= 1'b0;
    end else begin
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      key_strb_q <= key_strb_d;
      key_prss_q <= key_prss_d;
      key_ext_q  <= key_ext_d;
      key_code_q <= key_code_d;
      ctrl_q     <= ctrl_d;
      alt_q      <= alt_d;
      del_q      <= del_d;
      bksp_q     <= bksp_d;
      f6_q       <= f6_d;
      f7_q       <= f7_d;
      f8_q       <= f8_d;
      f11_q      <= f11_d;
      f12_q      <= f12_d;
    end
  end

  always_comb begin
    ext_d      = ext_q;
    brk_d      = brk_q;
    key_strb_d = key_strb_q;
    key_prss_d = key_prss_q;
    key_ext_d  = key_ext_q;
    key_code_d = key_code_q;
    ctrl_d     = ctrl_q;
    alt_d      = alt_q;
    del_d      = del_q;
    bksp_d     = bksp_q;
    f6_d       = f6_q;
    f7_d       = f7_q;
    f8_d       = f8_q;
    f11_d      = f11_q;
    f12_d      = f12_q;
    press      = ~brk_q;

    if (ce) begin
      key_strb_d = 1'b0;
      // A dropped frame must not leave a prefix attached to the next key.
      if (rx_error) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (byte_valid) begin
        if (rx_byte == SC_E0) begin
          ext_d = 1'b1;
        end else if (rx_byte == SC_F0) begin
          brk_d = 1'b1;
        end else begin
          key_strb_d = 1'b1;
          key_code_d = rx_byte;
          key_ext_d  = ext_q;
          key_prss_d = press;
          ext_d      = 1'b0;
          brk_d      = 1'b0;
          if (rx_byte == SC_CTRL)           ctrl_d = press;
          if (rx_byte == SC_ALT)            alt_d  = press;
          if (rx_byte == SC_DEL  &&  ext_q) del_d  = press;
          if (rx_byte == SC_BKSP)           bksp_d = press;
          if (rx_byte == SC_F6   && !ext_q) f6_d   = press;
          if (rx_byte == SC_F7   && !ext_q) f7_d   = press;
          if (rx_byte == SC_F8   && !ext_q) f8_d   = press;
          if (rx_byte == SC_F11  && !ext_q) f11_d  = press;
          if (rx_byte == SC_F12  && !ext_q) f12_d  = press;
        end
      end
    end
  end

  assign keyStrb = key_strb_q;
  assign keyPrss = key_prss_q;
  assign keyCode = key_code_q;
  assign keyExt  = key_ext_q;
  assign reset_n = ~(ctrl_q & alt_q & del_q);
  assign boot_n  = ~(ctrl_q & alt_q & bksp_q);
  assign f12     = ~f12_q;
  assign f11     = ~f11_q;
  assign f8      = ~f8_q;
  assign f7      = ~f7_q;
  assign f6      = ~f6_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: drives PS/2 frames at pin level and compares
// every key event and hot-key output against a behavioural keyboard model.
module tb_ps2_keyboard;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 200;
  localparam int HALF    = 15;

  logic       clock = 1'b0;
  logic       reset;
  logic       ce;
  logic [1:0] ps2;
  logic       keyStrb, keyPrss, keyExt, reset_n, boot_n, f12, f11, f8, f7, f6;
  logic [7:0] keyCode;

  always #5 clock = ~clock;

  ps2_keyboard #(
    .FILTER (FILTER),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .ce     (ce),
    .ps2    (ps2),
    .keyStrb(keyStrb),
    .keyPrss(keyPrss),
    .keyCode(keyCode),
    .keyExt (keyExt),
    .reset_n(reset_n),
    .boot_n (boot_n),
    .f12    (f12),
    .f11    (f11),
    .f8     (f8),
    .f7     (f7),
    .f6     (f6)
  );

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       prss;
    logic       rst_n;
    logic       boot_n;
    logic [4:0] fk;
  } ev_t;

  ev_t obs_q[$];
  int  long_pulses = 0;
  bit  strb_prev = 1'b0;
  int  checks = 0;
  int  errors = 0;

  // Capture every strobe together with the outputs visible in that same cycle.
  always @(negedge clock) begin
    if (keyStrb === 1'b1) begin
      if (strb_prev) long_pulses++;
      else obs_q.push_back('{keyCode, keyExt, keyPrss, reset_n, boot_n, {f12, f11, f8, f7, f6}});
    end
    strb_prev = (keyStrb === 1'b1);
  end

  // Keyboard model: pending prefixes plus the held state of each hot key.
  bit m_ext, m_brk;
  bit m_ctrl, m_alt, m_del, m_bksp, m_f6, m_f7, m_f8, m_f11, m_f12;

  function automatic void model_reset();
    m_ext = 0; m_brk = 0;
    m_ctrl = 0; m_alt = 0; m_del = 0; m_bksp = 0;
    m_f6 = 0; m_f7 = 0; m_f8 = 0; m_f11 = 0; m_f12 = 0;
  endfunction

  function automatic logic [4:0] exp_fk();
    return ~{m_f12, m_f11, m_f8, m_f7, m_f6};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    ps2[1] = b;
    wait_clk(HALF);
    if (glitch) begin
      ps2[0] = 1'b0;
      wait_clk(FILTER - 3);
      ps2[0] = 1'b1;
      wait_clk(HALF);
    end
    ps2[0] = 1'b0;
    wait_clk(HALF);
    ps2[0] = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits, input int glitch_bit);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i], i == glitch_bit);
    ps2[1] = 1'b1;
  endtask

  task automatic send_and_check(input logic [7:0] b, input bit bad_par, input int glitch_bit, input string tag);
    ev_t ev;
    obs_q.delete();
    send_bits(b, bad_par, 11, glitch_bit);
    wait_clk(HALF + 20);
    if (bad_par) begin
      m_ext = 0; m_brk = 0;
      check({tag, "_nostrb"}, obs_q.size(), 0);
    end else if (b == 8'hE0) begin
      m_ext = 1;
      check({tag, "_nostrb"}, obs_q.size(), 0);
    end else if (b == 8'hF0) begin
      m_brk = 1;
      check({tag, "_nostrb"}, obs_q.size(), 0);
    end else begin
      bit press;
      press = !m_brk;
      case (b)
        8'h14: m_ctrl = press;
        8'h11: m_alt = press;
        8'h71: if (m_ext) m_del = press;
        8'h66: m_bksp = press;
        8'h0B: if (!m_ext) m_f6 = press;
        8'h83: if (!m_ext) m_f7 = press;
        8'h0A: if (!m_ext) m_f8 = press;
        8'h78: if (!m_ext) m_f11 = press;
        8'h07: if (!m_ext) m_f12 = press;
        default: ;
      endcase
      ev = (obs_q.size() > 0) ? obs_q[0] : 'x;
      check({tag, "_strb"}, obs_q.size(), 1);
      check({tag, "_code"}, ev.code, b);
      check({tag, "_ext"}, ev.ext, m_ext);
      check({tag, "_prss"}, ev.prss, press);
      check({tag, "_reset_n"}, ev.rst_n, !(m_ctrl && m_alt && m_del));
      check({tag, "_boot_n"}, ev.boot_n, !(m_ctrl && m_alt && m_bksp));
      check({tag, "_fkeys"}, ev.fk, exp_fk());
      check({tag, "_code_held"}, keyCode, b);
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    send_and_check(b, 1'b0, -1, tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strb"}, keyStrb, 0);
    check({tag, "_prss"}, keyPrss, 0);
    check({tag, "_code"}, keyCode, 8'h00);
    check({tag, "_ext"}, keyExt, 0);
    check({tag, "_reset_n"}, reset_n, 1);
    check({tag, "_boot_n"}, boot_n, 1);
    check({tag, "_fkeys"}, {f12, f11, f8, f7, f6}, 5'b11111);
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  logic [7:0] fkeys_codes [5];
  logic [7:0] pool [14];

  initial begin
    fkeys_codes = '{8'h0B, 8'h83, 8'h0A, 8'h78, 8'h07};
    pool = '{8'hE0, 8'hF0, 8'hF0, 8'h14, 8'h11, 8'h71, 8'h66, 8'h07,
             8'h78, 8'h0A, 8'h83, 8'h0B, 8'h1C, 8'hE1};
    model_reset();
    reset = 1'b1;
    ce = 1'b1;
    ps2 = 2'b11;
    wait_clk(5);
    check_reset_outputs("por");
    reset = 1'b0;
    wait_clk(20);

    send(8'h1C, "make");
    send(8'hF0, "brk_pfx");
    send(8'h1C, "break");

    send(8'hE0, "ext_pfx");
    send(8'h75, "ext_make");
    send(8'hE0, "ext_pfx2");
    send(8'hF0, "ext_brk_pfx");
    send(8'h75, "ext_break");

    send(8'h14, "ctrl");
    send(8'h11, "alt");
    send(8'hE0, "del_pfx");
    send(8'h71, "del");
    send(8'hE0, "del_rel_pfx");
    send(8'hF0, "del_rel_pfx2");
    send(8'h71, "del_rel");
    send(8'h66, "bksp");
    send(8'hF0, "bksp_rel_pfx");
    send(8'h66, "bksp_rel");
    send(8'h66, "bksp_again");
    send(8'h66, "bksp_typematic");
    send(8'hF0, "bksp_rel_pfx2");
    send(8'h66, "bksp_rel2");
    send(8'hF0, "ctrl_rel_pfx");
    send(8'h14, "ctrl_rel");
    send(8'hF0, "alt_rel_pfx");
    send(8'h11, "alt_rel");

    for (int i = 0; i < 5; i++) begin
      send(fkeys_codes[i], $sformatf("fkey%0d_make", i));
      send(8'hF0, $sformatf("fkey%0d_pfx", i));
      send(fkeys_codes[i], $sformatf("fkey%0d_break", i));
    end

    send_and_check(8'h1C, 1'b1, -1, "bad_parity");
    send(8'h1C, "after_bad_parity");

    send(8'hF0, "to_pfx");
    obs_q.delete();
    send_bits(8'h33, 1'b0, 4, -1);
    wait_clk(TIMEOUT + 50);
    m_ext = 0; m_brk = 0;
    check("timeout_nostrb", obs_q.size(), 0);
    send(8'h1C, "after_timeout");

    send_and_check(8'h2A, 1'b0, 3, "glitch");

    send(8'h0B, "pre_reset_f6");
    send(8'h14, "pre_reset_ctrl");
    obs_q.delete();
    send_bits(8'hA5, 1'b0, 5, -1);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    model_reset();
    ps2 = 2'b11;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(20);
    send(8'h1C, "after_reset");

    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      bit bad;
      b = ($urandom_range(0, 5) == 0) ? 8'($urandom) : pool[$urandom_range(0, 13)];
      bad = ($urandom_range(0, 9) == 0);
      send_and_check(b, bad, -1, $sformatf("rand%0d", i));
    end

    check("strobe_width", long_pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard.md
# ps2_keyboard

PS/2 keyboard front end that feeds the machine core and the top-level control logic. It filters the raw PS/2 clock and data lines and deserialises 11-bit device-to-host frames. It decodes the E0/F0 prefixes into one key event per make or break code. It also keeps the live held-state of the hot keys: F6, F7, F8, F11, F12, Ctrl+Alt+Del and Ctrl+Alt+Backspace.

## Interface
Parameters:
- FILTER, 8: consecutive ce samples PS/2 clock must hold a level before it is accepted.
- TIMEOUT, 4095: ce cycles without a PS/2 clock fall before a partial frame is abandoned.

Ports:
- clock  in  1  system clock. One clock; reset is asynchronous and active-high.
- reset  in  1  asynchronous, active-high.
- ce  in  1  clock enable; all state advances only when ce=1.
- ps2  in  2  [0]=PS/2 clock, [1]=PS/2 data, asynchronous.
- keyStrb  out  1  one-ce-cycle pulse, new key event valid.
- keyPrss  out  1  1=make, 0=break; valid with keyStrb, then held.
- keyCode  out  8  scan code of the event, without prefixes; held.
- keyExt  out  1  event carried the E0 prefix; held.
- reset_n  out  1  low while Ctrl+Alt+Del is held.
- boot_n  out  1  low while Ctrl+Alt+Backspace is held.
- f12, f11, f8, f7, f6  out  1 each  low while the key is held.

## Operation
- **Input conditioning:** 2-FF synchronisers on both lines. The filtered PS/2 clock changes level only after FILTER consecutive equal ce samples. A falling edge of the filtered clock samples the synchronised data.
- **Receiver FSM:**
  - IDLE → on fall with data=0 (start bit) → DATA.
  - DATA: 8 bits, LSB first → PARITY.
  - PARITY → STOP.
  - STOP: requires data=1 and odd parity over 8 data bits + parity bit. On pass, emits byte_valid and returns to IDLE.
  - Bad start/stop/parity: byte dropped, prefix flags cleared, back to IDLE.
  - Timeout counter resets on every fall. Reaching TIMEOUT outside IDLE → IDLE; no byte emitted.
- **Decoder:**
  - 0xE0 sets ext; 0xF0 sets brk. Neither produces an event.
  - Any other byte: keyCode=byte, keyExt=ext, keyPrss=~brk, keyStrb=1. Then ext and brk clear.
  - 0xE1 (Pause) is treated as a plain code; no special handling.
- **Hot-key state:** held flags update on every event.
  - Ctrl = 14 (E0 or not); Alt = 11 (E0 or not); Del = E0 71; Backspace = 66.
  - F12=07, F11=78, F8=0A, F7=83, F6=0B, all non-extended only.
  - reset_n = ~(ctrl & alt & del); boot_n = ~(ctrl & alt & bksp).
- **Reset values:** keyStrb=0, keyPrss=0, keyCode=0x00, keyExt=0, reset_n=1, boot_n=1, all f*=1, FSM IDLE, prefix and held flags clear.

## Timing
- keyStrb rises on the first ce cycle after the stop-bit sample. It is high for exactly one ce-qualified cycle. keyCode, keyExt and keyPrss are stable in that cycle and hold until the next event.
- Held-flag outputs change in the same ce cycle as keyStrb.
- Filter latency: FILTER+2 ce cycles from a pin edge to a filtered edge.
- A prefix byte followed by a timeout or a bad frame leaves no stale prefix; both flags clear.
- Reset mid-frame: the partial byte is discarded and outputs return to reset values asynchronously.
- Repeated make codes (typematic) produce a keyStrb each time, with keyPrss=1; held flags are unchanged.

## Structure
- Package ps2_pkg:
  - scan-code constants SC_E0, SC_F0, SC_CTRL, SC_ALT, SC_DEL, SC_BKSP, SC_F6, SC_F7, SC_F8, SC_F11, SC_F12;
  - receiver state enum.
- Sub-module ps2_rx: synchronisers, filter, frame FSM and timeout. It outputs byte[7:0] and byte_valid.
- The top of ps2_keyboard holds the prefix decoder and the held flags.

## Test plan
- **Make and break:** frame 0x1C, then F0 and 1C → two keyStrb pulses with keyCode=0x1C, keyPrss=1 then 0, keyExt=0.
- **Extended key:** E0 75, E0 F0 75 → keyCode=0x75, keyExt=1, keyPrss 1 then 0; no strobe on any prefix byte.
- **Reset combo:** 14, 11, E0 71 → reset_n goes 0 in the cycle of the third strobe. Then E0 F0 71 → reset_n=1. Ctrl+Alt+66 → boot_n pulses low the same way.
- **Function keys:** 0B → f6=0, others 1. F0 0B → f6=1. Repeat for 83 (f7), 0A (f8), 78 (f11) and 07 (f12).
- **Error handling:** frame 0x1C with even parity → no strobe. Next valid 0x1C → strobe. F0 followed by a frame abandoned mid-byte past TIMEOUT, then 0x1C → keyPrss=1.
- **Glitch and reset:** a PS/2 clock glitch shorter than FILTER samples causes no bit shift. Asserting reset during bit 4 restores all reset values; the next full frame decodes correctly.
